// File: rtl/rot_sweep_pkg.sv
// Shared types and helpers for the rotate-sweep controller.
package rot_sweep_pkg;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Left rotation expressed as a right-rotate amount: (8-k) mod 8.
  function automatic logic [AMT_W-1:0] step_to_amt(input logic [AMT_W-1:0] k, input logic dir);
    return dir ? (AMT_W'(0) - k) : k;
  endfunction
endpackage

// File: rtl/rot_sweep_ctrl_tick.sv
// Mod-M tick counter: counts while enabled, synchronous clear, tick at M-1.
module mod_m_tick #(
  parameter int M = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= (cnt == W'(M-1)) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == W'(M-1));
endmodule

// File: rtl/rot_sweep_ctrl.sv
// Sweeps the rotate amount for a downstream rotate-right shifter.
// ROT_SWEEP_BOUNCE_EN selects a ping-pong k sequence instead of wrapping.
module rot_sweep_ctrl
  import rot_sweep_pkg::*;
#(
  parameter int TICK_CNT = 10_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dir,
  input  logic              cont,
  output logic [DATA_W-1:0] a,
  output logic [AMT_W-1:0]  amt,
  output logic              step_valid,
  output logic              busy,
  output logic              done
);
  state_t           state;
  logic [AMT_W-1:0] k, k_nxt;
  logic             dir_q, cont_q;
  logic             go, last, tick, cnt_clr;

  assign go      = (state == IDLE) && start && !stop;
  assign cnt_clr = stop || (state != RUN);

  mod_m_tick #(.M(TICK_CNT)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == RUN),
    .clr     (cnt_clr),
    .tick    (tick)
  );

`ifdef ROT_SWEEP_BOUNCE_EN
  // down marks the descending half; k=0 with down set is the final step.
  logic down, down_nxt;

  always_comb begin
    last     = (k == '0) && down;
    k_nxt    = k + 1'b1;
    down_nxt = down;
    if (down) begin
      if (k == '0) begin
        k_nxt    = AMT_W'(1);
        down_nxt = 1'b0;
      end else begin
        k_nxt = k - 1'b1;
      end
    end else if (k == '1) begin
      k_nxt    = k - 1'b1;
      down_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         down <= 1'b0;
    else if (go || (state != RUN) || stop) down <= 1'b0;
    else if (tick)                        down <= down_nxt;
  end
`else
  always_comb begin
    last  = (k == '1);
    k_nxt = k + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      a          <= '0;
      amt        <= '0;
      k          <= '0;
      dir_q      <= 1'b0;
      cont_q     <= 1'b0;
      step_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (go) begin
          a          <= data_in;
          dir_q      <= dir;
          cont_q     <= cont;
          k          <= '0;
          amt        <= '0;
          step_valid <= 1'b1;
          busy       <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            amt   <= '0;
            k     <= '0;
            busy  <= 1'b0;
          end else if (tick) begin
            if (last && !cont_q) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              k          <= k_nxt;
              amt        <= step_to_amt(k_nxt, dir_q);
              step_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          amt   <= '0;
          k     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rot_sweep_ctrl.sv
// Scoreboard bench for rot_sweep_ctrl with TICK_CNT=4 and a behavioural shifter.
module tb_rot_sweep_ctrl;
  localparam int TICK = 4;
`ifdef ROT_SWEEP_BOUNCE_EN
  localparam int NSTEPS = 15;
`else
  localparam int NSTEPS = 8;
`endif

  logic       clk = 1'b0;
  logic       reset_n, start, stop, dir, cont;
  logic [7:0] data_in, a, y;
  logic [2:0] amt;
  logic       step_valid, busy, done;

  rot_sweep_ctrl #(.TICK_CNT(TICK)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .data_in(data_in), .dir(dir), .cont(cont),
    .a(a), .amt(amt), .step_valid(step_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] w;
    w = {v, v} >> s;
    return w[7:0];
  endfunction

  assign y = rotr(a, amt);

  // Expected k at step i of a sweep.
  function automatic logic [2:0] k_at(input int i);
`ifdef ROT_SWEEP_BOUNCE_EN
    int p;
    p = i % 14;
    return (p <= 7) ? 3'(p) : 3'(14 - p);
`else
    return 3'(i % 8);
`endif
  endfunction

  function automatic logic [2:0] amt_of(input logic [2:0] kk, input logic d);
    logic [3:0] t;
    t = 4'd8 - {1'b0, kk};
    return d ? t[2:0] : kk;
  endfunction

  typedef struct {
    logic [2:0] amt;
    logic [7:0] y;
    int         cyc;
  } step_t;

  step_t sq[$];
  int    dq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected steps / done pulses whenever the DUT presents them.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (step_valid) begin
        if (sq.size() == 0) chk("unexpected_step", {29'd0, amt}, 32'hFFFF_FFFF);
        else begin
          step_t e;
          e = sq.pop_front();
          chk("step_amt", {29'd0, amt}, {29'd0, e.amt});
          chk("step_y",   {24'd0, y},   {24'd0, e.y});
          chk("step_cyc", cyc,          e.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", cyc, 32'hFFFF_FFFF);
        else begin
          chk("done_cyc",  cyc, dq.pop_front());
          chk("done_amt",  {29'd0, amt}, 32'd0);
          chk("done_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic push_sweep(input logic [7:0] d, input logic dr, input int t0, input int n);
    for (int i = 0; i < n; i++) begin
      step_t e;
      e.amt = amt_of(k_at(i), dr);
      e.y   = rotr(d, e.amt);
      e.cyc = t0 + 1 + TICK * i;
      sq.push_back(e);
    end
  endtask

  task automatic do_start(input logic [7:0] d, input logic dr, input logic c, output int t0);
    @(negedge clk);
    data_in = d; dir = dr; cont = c; start = 1'b1;
    t0 = cyc;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((sq.size() != 0 || dq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sq.size() + dq.size(), 0);
  endtask

  initial begin
    int t0;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; cont = 1'b0; data_in = 8'h00;
    #12;
    chk("reset_outputs", {19'd0, a, amt, step_valid, busy, done}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Reset mid-sweep at k=3: outputs clear asynchronously, no done afterwards.
    do_start(8'hA5, 1'b0, 1'b0, t0);
    push_sweep(8'hA5, 1'b0, t0, 4);
    release_start();
    wait_until(t0 + 14);
    chk("k3_amt_before_reset", {29'd0, amt}, 32'd3);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {19'd0, a, amt, step_valid, busy, done}, 32'd0);
    chk("steps_before_reset", sq.size(), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // One-shot right rotate of 0x81.
    do_start(8'h81, 1'b0, 1'b0, t0);
    push_sweep(8'h81, 1'b0, t0, NSTEPS);
    dq.push_back(t0 + 2 + TICK * NSTEPS);
    release_start();
    drain();
    chk("a_retained", {24'd0, a}, 32'h81);

    // One-shot left rotate of 0x01.
    do_start(8'h01, 1'b1, 1'b0, t0);
    push_sweep(8'h01, 1'b1, t0, NSTEPS);
    dq.push_back(t0 + 2 + TICK * NSTEPS);
    release_start();
    drain();

    // Continuous, stopped at cycle 50: 13 steps, no done.
    do_start(8'h81, 1'b0, 1'b1, t0);
    push_sweep(8'h81, 1'b0, t0, 13);
    release_start();
    wait_until(t0 + 51);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_amt",  {29'd0, amt}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_steps_left", sq.size(), 0);
    repeat (40) @(negedge clk);

    // start & stop together in IDLE: stop wins.
    @(negedge clk);
    data_in = 8'h55; dir = 1'b0; cont = 1'b0; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", {31'd0, busy}, 32'd0);
    chk("start_stop_sv",   {31'd0, step_valid}, 32'd0);

    // start during RUN is ignored.
    do_start(8'h3C, 1'b0, 1'b0, t0);
    push_sweep(8'h3C, 1'b0, t0, NSTEPS);
    dq.push_back(t0 + 2 + TICK * NSTEPS);
    release_start();
    wait_until(t0 + 10);
    data_in = 8'hFF; dir = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("a_unchanged", {24'd0, a}, 32'h3C);
    drain();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
